// File: rtl/tlc5955_pkg.sv
// tlc5955_pkg
// Types and constants shared by the TLC5955 frame loader.
//   state_t         - frame loader sequencing states
//   TLC_*_LEN       - shifter LEN codes for the three chunk kinds
//   TLC_PACKET_BITS - serial bits per chip (1 header + 48 x 16)
//   chunk_a_data / chunk_b_data - split of a chip's first word around the header bit
package tlc5955_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LOAD,
        S_WAIT,
        S_GAP,
        S_LATCH,
        S_FIN
    } state_t;

    localparam logic [4:0] TLC_CHUNK_A_LEN = 5'd2;
    localparam logic [4:0] TLC_CHUNK_B_LEN = 5'd15;
    localparam logic [4:0] TLC_WORD_LEN    = 5'd16;
    localparam int         TLC_PACKET_BITS = 769;

    // The shifter cannot send a lone header bit (LEN=1 gives no DONE), so the
    // header rides with the MSB of the first word, and the remaining 15 bits follow.
    function automatic logic [15:0] chunk_a_data(input logic hdr, input logic [15:0] w);
        return {14'b0, hdr, w[15]};
    endfunction

    function automatic logic [15:0] chunk_b_data(input logic [15:0] w);
        return {1'b0, w[14:0]};
    endfunction

endpackage

// File: rtl/tlc5955_frame_loader.sv
// tlc5955_frame_loader
// Streams one daisy-chain packet (per chip: header bit + CH_PER_CHIP words) from
// the frame RAM into the TLC5955 serial shifter, then pulses LAT.
// Ports:
//   CLK, nRESET          - clock, async active-low reset
//   FRAME_START, HDR     - frame request and header bit (captured together in IDLE)
//   BUSY, FRAME_DONE     - frame in progress / one-cycle end-of-frame pulse
//   RD_ADDR, RD_DATA     - frame RAM read port, 1-cycle read latency
//   TX_START/DATA/LEN    - chunk request to the shifter
//   TX_DONE              - chunk complete from the shifter
//   LAT                  - latch strobe to the chain
module tlc5955_frame_loader
    import tlc5955_pkg::*;
#(
    parameter int N_CHIPS     = 1,
    parameter int CH_PER_CHIP = 48,
    parameter int ADDR_W      = 8,
    parameter int LAT_CYCLES  = 2
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              FRAME_START,
    input  logic              HDR,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [15:0]       RD_DATA,
    output logic              TX_START,
    output logic [15:0]       TX_DATA,
    output logic [4:0]        TX_LEN,
    input  logic              TX_DONE,
    output logic              LAT
);

    localparam int CHIP_W = $clog2(N_CHIPS + 1);
    localparam int CH_W   = $clog2(CH_PER_CHIP);
    localparam int LAT_W  = $clog2(LAT_CYCLES + 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(N_CHIPS - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CH_PER_CHIP - 1);

    function automatic logic [ADDR_W-1:0] word_addr(input logic [CHIP_W-1:0] c,
                                                    input logic [CH_W-1:0]   k);
        return ADDR_W'(c) * ADDR_W'(CH_PER_CHIP) + ADDR_W'(k);
    endfunction

    state_t              state_q, state_d;
    logic                hdr_q, hdr_d;
    logic [CHIP_W-1:0]   chip_q, chip_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [15:0]         word_q, word_d;
    logic                b_pend_q, b_pend_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                tx_start_q, tx_start_d;
    logic [15:0]         tx_data_q, tx_data_d;
    logic [4:0]          tx_len_q, tx_len_d;
    logic                lat_q, lat_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        chip_d       = chip_q;
        ch_d         = ch_q;
        word_d       = word_q;
        b_pend_d     = b_pend_q;
        rd_addr_d    = rd_addr_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        tx_len_d     = tx_len_q;
        lat_d        = lat_q;
        lat_cnt_d    = lat_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            // RD_ADDR is registered on the way into RD so it is already on the
            // bus during RD; the RAM answers during LOAD.
            S_IDLE: begin
                if (FRAME_START) begin
                    hdr_d     = HDR;
                    chip_d    = CHIP_LAST;
                    ch_d      = CH_LAST;
                    busy_d    = 1'b1;
                    rd_addr_d = word_addr(CHIP_LAST, CH_LAST);
                    state_d   = S_RD;
                end
            end
            S_RD: state_d = S_LOAD;
            S_LOAD: begin
                word_d     = RD_DATA;
                tx_start_d = 1'b1;
                if (ch_q == CH_LAST) begin
                    tx_data_d = chunk_a_data(hdr_q, RD_DATA);
                    tx_len_d  = TLC_CHUNK_A_LEN;
                    b_pend_d  = 1'b1;
                end else begin
                    tx_data_d = RD_DATA;
                    tx_len_d  = TLC_WORD_LEN;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (TX_DONE) state_d = S_GAP;
            end
            // One idle cycle lets the shifter settle before the next START.
            S_GAP: begin
                if (b_pend_q) begin
                    b_pend_d   = 1'b0;
                    tx_start_d = 1'b1;
                    tx_data_d  = chunk_b_data(word_q);
                    tx_len_d   = TLC_CHUNK_B_LEN;
                    state_d    = S_WAIT;
                end else if (ch_q != '0) begin
                    ch_d      = ch_q - 1'b1;
                    rd_addr_d = word_addr(chip_q, ch_q - 1'b1);
                    state_d   = S_RD;
                end else if (chip_q != '0) begin
                    chip_d    = chip_q - 1'b1;
                    ch_d      = CH_LAST;
                    rd_addr_d = word_addr(chip_q - 1'b1, CH_LAST);
                    state_d   = S_RD;
                end else begin
                    lat_d     = 1'b1;
                    lat_cnt_d = LAT_W'(LAT_CYCLES - 1);
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: begin
                if (lat_cnt_q == '0) begin
                    lat_d        = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = S_FIN;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            // BUSY stays up through the FRAME_DONE cycle and drops after it.
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= S_IDLE;
            hdr_q        <= 1'b0;
            chip_q       <= '0;
            ch_q         <= '0;
            word_q       <= '0;
            b_pend_q     <= 1'b0;
            rd_addr_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_len_q     <= '0;
            lat_q        <= 1'b0;
            lat_cnt_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            chip_q       <= chip_d;
            ch_q         <= ch_d;
            word_q       <= word_d;
            b_pend_q     <= b_pend_d;
            rd_addr_q    <= rd_addr_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            tx_len_q     <= tx_len_d;
            lat_q        <= lat_d;
            lat_cnt_q    <= lat_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;
    assign RD_ADDR    = rd_addr_q;
    assign TX_START   = tx_start_q;
    assign TX_DATA    = tx_data_q;
    assign TX_LEN     = tx_len_q;
    assign LAT        = lat_q;

endmodule
